// File: rtl/swerv_el2_trace_pkg.sv
// Shared types for the EL2 trace packer: record layout, event kinds, per-cycle limits.
// Optional TRACE_TIMESTAMP_EN appends a 32-bit cycle stamp to every record.
package swerv_el2_trace_pkg;

  typedef enum logic [2:0] {
    TRK_IF  = 3'd0,
    TRK_DE  = 3'd1,
    TRK_EX  = 3'd2,
    TRK_WB  = 3'd3,
    TRK_OVF = 3'd4
  } trace_kind_e;

  localparam int MAX_EV_PER_CYC = 4;
  // one overflow marker can precede the events of a cycle
  localparam int MAX_WR_PER_CYC = MAX_EV_PER_CYC + 1;

`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_W = 99;
  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] insn;
    logic [31:0] pc;
    trace_kind_e kind;
  } trace_rec_t;
`else
  localparam int REC_W = 67;
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    trace_kind_e kind;
  } trace_rec_t;
`endif

  function automatic trace_rec_t mk_rec(trace_kind_e kind, logic [31:0] pc, logic [31:0] insn);
    trace_rec_t r;
    r      = '0;
    r.kind = kind;
    r.pc   = pc;
    r.insn = insn;
    return r;
  endfunction

endpackage

// File: rtl/swerv_el2_trace_fifo.sv
// Multi-write (up to MAX_WR_PER_CYC per cycle), single-read first-word-fall-through record store.
// Head visible same cycle as level != 0; caller guarantees writes never exceed free space.
module swerv_el2_trace_fifo
  import swerv_el2_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_l,
  input  logic [2:0]                          wr_cnt,
  input  trace_rec_t [MAX_WR_PER_CYC-1:0]     wr_dat,
  input  logic                                rd_pop,
  output logic                                rd_vld,
  output trace_rec_t                          rd_dat,
  output logic [$clog2(DEPTH):0]              level
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  assign rd_vld = (level != '0);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  // entries beyond wr_cnt are don't-care; slot i lands at wr_ptr+i modulo DEPTH
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_WR_PER_CYC; i++) begin
      if (i < int'(wr_cnt)) mem[wr_ptr + AW'(i)] <= wr_dat[i];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(rd_pop);
      level  <= level + (AW+1)'(wr_cnt) - (AW+1)'(rd_pop);
    end
  end

endmodule

// File: rtl/swerv_el2_trace_packer.sv
// Packs IF/DE/EX/WB trace taps into records, buffers them and streams one per cycle (valid/ready).
// All-or-nothing per cycle on lack of space; TRACE_TIMESTAMP_EN adds a shared per-cycle stamp.
module swerv_el2_trace_packer
  import swerv_el2_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int OVF_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     trc_en,
  input  logic                     if_req,
  input  logic [31:0]              if_pc,
  input  logic                     de_valid,
  input  logic [31:0]              de_pc,
  input  logic [31:0]              de_insn,
  input  logic                     ex_valid,
  input  logic [31:0]              ex_pc,
  input  logic [1:0]               wb_valid,
  input  logic [31:0]              wb_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REC_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [OVF_CNT_W-1:0]     ovf_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                              if_req_q;
  logic [31:0]                       if_pc_q;
  logic                              ovf_pending;
  logic [MAX_EV_PER_CYC-1:0]         ev_vld;
  trace_rec_t                        ev_rec [MAX_EV_PER_CYC];
  logic [2:0]                        n_ev;
  logic [2:0]                        req_cnt;
  logic [2:0]                        wr_cnt;
  logic [2:0]                        slot;
  logic [LW:0]                       free_cnt;
  logic                              accept;
  logic                              pop;
  logic [OVF_CNT_W:0]                ovf_sum;
  trace_rec_t [MAX_WR_PER_CYC-1:0]   wr_dat;
  trace_rec_t                        head;

  // oldest stage first: WB, EX, DE, IF
  always_comb begin
    ev_vld[0] = trc_en && (|wb_valid);
    ev_vld[1] = trc_en && ex_valid;
    ev_vld[2] = trc_en && de_valid;
    ev_vld[3] = trc_en && if_req && (!if_req_q || (if_pc != if_pc_q));
    ev_rec[0] = mk_rec(TRK_WB, wb_pc, 32'd0);
    ev_rec[1] = mk_rec(TRK_EX, ex_pc, 32'd0);
    ev_rec[2] = mk_rec(TRK_DE, de_pc, de_insn);
    ev_rec[3] = mk_rec(TRK_IF, if_pc, 32'd0);
    n_ev = '0;
    for (int i = 0; i < MAX_EV_PER_CYC; i++) n_ev = n_ev + 3'(ev_vld[i]);
  end

  assign pop      = out_valid && out_ready;
  assign req_cnt  = n_ev + 3'(ovf_pending);
  assign free_cnt = (LW+1)'(DEPTH) - (LW+1)'(fifo_level) + (LW+1)'(pop);
  assign accept   = free_cnt >= (LW+1)'(req_cnt);
  assign wr_cnt   = accept ? req_cnt : 3'd0;
  assign ovf_sum  = (OVF_CNT_W+1)'(ovf_count) + (OVF_CNT_W+1)'(n_ev);

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // prefix-count slot assignment, overflow marker (if owed) takes slot 0
  always_comb begin
    wr_dat = '0;
    slot   = '0;
    if (ovf_pending) begin
      wr_dat[0] = mk_rec(TRK_OVF, 32'(ovf_count), 32'd0);
      slot      = 3'd1;
    end
    for (int i = 0; i < MAX_EV_PER_CYC; i++) begin
      if (ev_vld[i]) begin
        wr_dat[slot] = ev_rec[i];
        slot         = slot + 3'd1;
      end
    end
`ifdef TRACE_TIMESTAMP_EN
    for (int i = 0; i < MAX_WR_PER_CYC; i++) wr_dat[i].ts = ts_cnt;
`endif
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      if_req_q    <= 1'b0;
      if_pc_q     <= '0;
      ovf_pending <= 1'b0;
      ovf_count   <= '0;
    end else begin
      if_req_q <= if_req;
      if_pc_q  <= if_pc;
      if (accept) begin
        ovf_pending <= 1'b0;
      end else begin
        ovf_pending <= 1'b1;
        ovf_count   <= ovf_sum[OVF_CNT_W] ? '1 : ovf_sum[OVF_CNT_W-1:0];
      end
    end
  end

  swerv_el2_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_l  (rst_l),
    .wr_cnt (wr_cnt),
    .wr_dat (wr_dat),
    .rd_pop (pop),
    .rd_vld (out_valid),
    .rd_dat (head),
    .level  (fifo_level)
  );

  assign out_data = head;

endmodule

// File: tb/tb_swerv_el2_trace_packer.sv
// Directed bench for swerv_el2_trace_packer (DEPTH=16); stamp checks only when TRACE_TIMESTAMP_EN is set.
module tb_swerv_el2_trace_packer;
  import swerv_el2_trace_pkg::*;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              trc_en;
  logic              if_req;
  logic [31:0]       if_pc;
  logic              de_valid;
  logic [31:0]       de_pc;
  logic [31:0]       de_insn;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [1:0]        wb_valid;
  logic [31:0]       wb_pc;
  logic              out_valid;
  logic              out_ready;
  logic [REC_W-1:0]  out_data;
  logic [4:0]        fifo_level;
  logic [15:0]       ovf_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  swerv_el2_trace_packer #(.DEPTH(16), .OVF_CNT_W(16)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .trc_en     (trc_en),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .de_valid   (de_valid),
    .de_pc      (de_pc),
    .de_insn    (de_insn),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .ovf_count  (ovf_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req   = 1'b0;
    de_valid = 1'b0;
    ex_valid = 1'b0;
    wb_valid = 2'b00;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; trc_en = 1'b1; out_ready = 1'b0;
    if_pc = '0; de_pc = '0; de_insn = '0; ex_pc = '0; wb_pc = '0;
    idle();
    tick(); tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else pass_cnt++;
    chk_cnt++; if (ovf_count !== 16'd0) $display("FAIL reset_ovf: got %0d want 0", ovf_count); else pass_cnt++;
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_single_de();
    out_ready = 1'b1;
    de_valid = 1'b1; de_pc = 32'h100; de_insn = 32'h0000_0013;
    tick();
    idle();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data[2:0] !== 3'd1) $display("FAIL single_kind: got %0d want 1", out_data[2:0]); else pass_cnt++;
    chk_cnt++; if (out_data[34:3] !== 32'h100) $display("FAIL single_pc: got %h want 100", out_data[34:3]); else pass_cnt++;
    chk_cnt++; if (out_data[66:35] !== 32'h13) $display("FAIL single_insn: got %h want 13", out_data[66:35]); else pass_cnt++;
    tick();
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL single_drain: got %0d want 0", fifo_level); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_multi_event();
    logic [2:0]  exp_kind [4];
    logic [31:0] exp_pc   [4];
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] stamp0;
`endif
    exp_kind[0] = 3'd3; exp_kind[1] = 3'd2; exp_kind[2] = 3'd1; exp_kind[3] = 3'd0;
    exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18; exp_pc[3] = 32'h1C;
    out_ready = 1'b0;
    wb_valid = 2'b01; wb_pc = 32'h10;
    ex_valid = 1'b1;  ex_pc = 32'h14;
    de_valid = 1'b1;  de_pc = 32'h18; de_insn = 32'hDEAD_BEEF;
    if_req   = 1'b1;  if_pc = 32'h1C;
    tick();
    idle();
    chk_cnt++; if (fifo_level !== 5'd4) $display("FAIL multi_level: got %0d want 4", fifo_level); else pass_cnt++;
`ifdef TRACE_TIMESTAMP_EN
    stamp0 = out_data[98:67];
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (out_data[2:0] !== exp_kind[k]) $display("FAIL multi_kind%0d: got %0d want %0d", k, out_data[2:0], exp_kind[k]); else pass_cnt++;
      chk_cnt++; if (out_data[34:3] !== exp_pc[k]) $display("FAIL multi_pc%0d: got %h want %h", k, out_data[34:3], exp_pc[k]); else pass_cnt++;
      if (k == 2) begin
        chk_cnt++; if (out_data[66:35] !== 32'hDEAD_BEEF) $display("FAIL multi_de_insn: got %h want deadbeef", out_data[66:35]); else pass_cnt++;
      end else begin
        chk_cnt++; if (out_data[66:35] !== 32'h0) $display("FAIL multi_insn%0d: got %h want 0", k, out_data[66:35]); else pass_cnt++;
      end
`ifdef TRACE_TIMESTAMP_EN
      chk_cnt++; if (out_data[98:67] !== stamp0) $display("FAIL multi_stamp%0d: got %h want %h", k, out_data[98:67], stamp0); else pass_cnt++;
`endif
      tick();
    end
    out_ready = 1'b0;
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL multi_drain: got %0d want 0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_if_dedup();
    out_ready = 1'b0;
    if_req = 1'b1; if_pc = 32'h200;
    tick(); tick(); tick();
    if_pc = 32'h204;
    tick();
    idle();
    tick();
    chk_cnt++; if (fifo_level !== 5'd2) $display("FAIL ifdedup_level: got %0d want 2", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk_cnt++; if (out_data[2:0] !== 3'd0) $display("FAIL ifdedup_kind%0d: got %0d want 0", k, out_data[2:0]); else pass_cnt++;
      chk_cnt++; if (out_data[34:3] !== 32'h200 + 32'(4 * k)) $display("FAIL ifdedup_pc%0d: got %h want %h", k, out_data[34:3], 32'h200 + 32'(4 * k)); else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_trc_en();
    trc_en = 1'b0;
    de_valid = 1'b1; de_pc = 32'h600;
    if_req = 1'b1; if_pc = 32'h640;
    tick();
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL trcen_off_level: got %0d want 0", fifo_level); else pass_cnt++;
    trc_en = 1'b1; de_valid = 1'b0;
    tick();
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL trcen_ifq_level: got %0d want 0", fifo_level); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_overflow();
    logic [2:0]  ek;
    logic [31:0] ep;
    out_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      de_valid = 1'b1; de_pc = 32'h1000 + 32'(4 * i); de_insn = 32'(i);
      tick();
    end
    idle();
    chk_cnt++; if (fifo_level !== 5'd14) $display("FAIL ovf_fill: got %0d want 14", fifo_level); else pass_cnt++;
    wb_valid = 2'b10; wb_pc = 32'h2000;
    ex_valid = 1'b1;  ex_pc = 32'h2004;
    de_valid = 1'b1;  de_pc = 32'h2008;
    if_req   = 1'b1;  if_pc = 32'h200C;
    tick();
    idle();
    chk_cnt++; if (fifo_level !== 5'd14) $display("FAIL ovf_drop_level: got %0d want 14", fifo_level); else pass_cnt++;
    chk_cnt++; if (ovf_count !== 16'd4) $display("FAIL ovf_count: got %0d want 4", ovf_count); else pass_cnt++;
    tick();
    chk_cnt++; if (fifo_level !== 5'd15) $display("FAIL ovf_marker_level: got %0d want 15", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_cnt++; if (out_data[34:3] !== 32'h1000 + 32'(4 * k)) $display("FAIL ovf_drain_pc%0d: got %h want %h", k, out_data[34:3], 32'h1000 + 32'(4 * k)); else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
    chk_cnt++; if (fifo_level !== 5'd10) $display("FAIL ovf_after_drain: got %0d want 10", fifo_level); else pass_cnt++;
    ex_valid = 1'b1; ex_pc = 32'h400;
    de_valid = 1'b1; de_pc = 32'h404; de_insn = 32'hABC;
    tick();
    idle();
    chk_cnt++; if (fifo_level !== 5'd12) $display("FAIL ovf_resume_level: got %0d want 12", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 5; k < 17; k++) begin
      if (k < 14)       begin ek = 3'd1; ep = 32'h1000 + 32'(4 * k); end
      else if (k == 14) begin ek = 3'd4; ep = 32'd4; end
      else if (k == 15) begin ek = 3'd2; ep = 32'h400; end
      else              begin ek = 3'd1; ep = 32'h404; end
      chk_cnt++; if (out_data[2:0] !== ek) $display("FAIL ovf_seq_kind%0d: got %0d want %0d", k, out_data[2:0], ek); else pass_cnt++;
      chk_cnt++; if (out_data[34:3] !== ep) $display("FAIL ovf_seq_pc%0d: got %h want %h", k, out_data[34:3], ep); else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL ovf_final_level: got %0d want 0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_full_rw();
    logic [31:0] ep;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      de_valid = 1'b1; de_pc = 32'h3000 + 32'(4 * i); de_insn = '0;
      tick();
    end
    idle();
    chk_cnt++; if (fifo_level !== 5'd16) $display("FAIL full_level: got %0d want 16", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    de_valid = 1'b1; de_pc = 32'h500;
    tick();
    idle();
    out_ready = 1'b0;
    chk_cnt++; if (fifo_level !== 5'd16) $display("FAIL full_rw_level: got %0d want 16", fifo_level); else pass_cnt++;
    chk_cnt++; if (ovf_count !== 16'd4) $display("FAIL full_rw_ovf: got %0d want 4", ovf_count); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ep = (k < 15) ? 32'h3004 + 32'(4 * k) : 32'h500;
      chk_cnt++; if (out_data[34:3] !== ep) $display("FAIL full_seq_pc%0d: got %h want %h", k, out_data[34:3], ep); else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL full_final_level: got %0d want 0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      de_valid = 1'b1; de_pc = 32'h800 + 32'(4 * i);
      tick();
    end
    idle();
    chk_cnt++; if (fifo_level !== 5'd7) $display("FAIL rstmid_fill: got %0d want 7", fifo_level); else pass_cnt++;
    #2 rst_l = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL rstmid_level: got %0d want 0", fifo_level); else pass_cnt++;
    chk_cnt++; if (ovf_count !== 16'd0) $display("FAIL rstmid_ovf: got %0d want 0", ovf_count); else pass_cnt++;
    #2 rst_l = 1'b1;
    de_valid = 1'b1; de_pc = 32'h700; de_insn = 32'h55;
    tick();
    idle();
    chk_cnt++; if (fifo_level !== 5'd1) $display("FAIL rstmid_after_level: got %0d want 1", fifo_level); else pass_cnt++;
    chk_cnt++; if (out_data[34:3] !== 32'h700) $display("FAIL rstmid_after_pc: got %h want 700", out_data[34:3]); else pass_cnt++;
`ifdef TRACE_TIMESTAMP_EN
    chk_cnt++; if (out_data[98:67] !== 32'd0) $display("FAIL rstmid_stamp: got %h want 0", out_data[98:67]); else pass_cnt++;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_de();
    test_multi_event();
    test_if_dedup();
    test_trc_en();
    test_overflow();
    test_full_rw();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
